// File: rtl/axi_read_burst_split.sv
// AXI4 read master that streams a beat-aligned byte range out of AXI-Stream,
// split into INCR bursts of at most C_MAX_BURST_LEN beats that never cross a 4KB page.
module axi_read_burst_split #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST_LEN    = 16,
    parameter int unsigned C_LEN_WIDTH        = 20
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arlock,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic                          m_axi_rlast,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          run,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr,
    input  logic [C_LEN_WIDTH-1:0]        byte_length,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);
    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
    localparam int unsigned LW    = C_LEN_WIDTH;
    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned SH    = $clog2(BYTES);
    localparam int unsigned CW    = (LW > 13) ? LW : 13;
    localparam int unsigned NW    = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Burst length: limited by remaining beats, max burst and room left in the 4KB page
    function automatic logic [NW-1:0] burst_len(input logic [11:0] a_lo, input logic [LW-1:0] beats);
        logic [CW-1:0] room;
        logic [CW-1:0] n;
        room = CW'((13'd4096 - {1'b0, a_lo}) >> SH);
        n    = CW'(beats);
        if (n > CW'(C_MAX_BURST_LEN)) n = CW'(C_MAX_BURST_LEN);
        if (n > room) n = room;
        return NW'(n);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] beats_left_q, beats_left_d;
    logic [NW-1:0] burst_n_q, burst_n_d;
    logic [NW-1:0] beat_cnt_q, beat_cnt_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic [7:0]    arlen_q, arlen_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [AW-1:0] start_aligned;
    logic [LW-1:0] start_beats;
    logic [AW-1:0] next_addr;
    logic [LW-1:0] next_beats;
    logic [NW-1:0] n_start;
    logic [NW-1:0] n_next;
    logic          in_data;
    logic          beat;

    assign start_aligned = start_addr & ~AW'(BYTES - 1);
    assign start_beats   = LW'(byte_length >> SH);
    assign next_addr     = addr_q + (AW'(burst_n_q) << SH);
    assign next_beats    = beats_left_q - LW'(burst_n_q);
    assign n_start       = burst_len(start_aligned[11:0], start_beats);
    assign n_next        = burst_len(next_addr[11:0], next_beats);
    assign in_data       = (state_q == S_DATA);
    assign beat          = in_data && m_axi_rvalid && m_axis_tready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        burst_n_d    = burst_n_q;
        beat_cnt_d   = beat_cnt_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        arlen_d      = arlen_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    addr_d       = start_aligned;
                    beats_left_d = start_beats;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    if (start_beats == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ADDR;
                        burst_n_d = n_start;
                        arvalid_d = 1'b1;
                        araddr_d  = start_aligned;
                        arlen_d   = 8'(n_start - NW'(1));
                    end
                end
            end
            S_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d  = 1'b0;
                    arlen_d    = 8'd0;
                    beat_cnt_d = burst_n_q;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                // The beat counter, not rlast, decides where the burst ends
                if (beat) begin
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    if (m_axi_rlast != (beat_cnt_q == NW'(1))) err_d = 1'b1;
                    beat_cnt_d = beat_cnt_q - NW'(1);
                    if (beat_cnt_q == NW'(1)) begin
                        addr_d       = next_addr;
                        beats_left_d = next_beats;
                        if (next_beats != '0) begin
                            state_d   = S_ADDR;
                            burst_n_d = n_next;
                            arvalid_d = 1'b1;
                            araddr_d  = next_addr;
                            arlen_d   = 8'(n_next - NW'(1));
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            burst_n_q    <= '0;
            beat_cnt_q   <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            arlen_q      <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            burst_n_q    <= burst_n_d;
            beat_cnt_q   <= beat_cnt_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            arlen_q      <= arlen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SH);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arlock  = 1'b0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    // Stream side is a zero-latency pass-through while a burst is in flight
    assign m_axi_rready  = in_data && m_axis_tready;
    assign m_axis_tvalid = in_data && m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = in_data && (beat_cnt_q == NW'(1)) && (beats_left_q == LW'(burst_n_q));
endmodule

// File: tb/tb_axi_read_burst_split.sv
// Randomized bench for axi_read_burst_split: an AXI slave/stream sink driven
// against a burst-list reference model computed from addresses and lengths.
module tb_axi_read_burst_split;
    logic        clk;
    logic        rst;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arlock;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        m_axi_rlast;
    logic [1:0]  m_axi_rresp;
    logic        run;
    logic [31:0] start_addr;
    logic [19:0] byte_length;
    logic        busy;
    logic        done;
    logic        err;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;

    int n_checks;
    int n_errors;

    axi_read_burst_split #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(64),
        .C_MAX_BURST_LEN   (16),
        .C_LEN_WIDTH       (20)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arlock (m_axi_arlock),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rresp  (m_axi_rresp),
        .run          (run),
        .start_addr   (start_addr),
        .byte_length  (byte_length),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_araddr"}, m_axi_araddr, 0);
        check_eq({tag, "_arvalid"}, m_axi_arvalid, 0);
        check_eq({tag, "_arlen"}, m_axi_arlen, 0);
        check_eq({tag, "_rready"}, m_axi_rready, 0);
        check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_tlast"}, m_axis_tlast, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    // One transfer: resp_bad / rlast_bad are 1-based beat numbers to corrupt (0 = none);
    // abort_at > 0 resets the DUT mid-data after that many beats.
    task automatic do_xfer(input logic [31:0] a, input int unsigned len, input int unsigned tr_pct,
                           input int unsigned rv_pct, input int unsigned ar_dly,
                           input int unsigned resp_bad, input int unsigned rlast_bad,
                           input int unsigned abort_at);
        logic [31:0] qa[$];
        int unsigned ql[$];
        logic [31:0] ma;
        logic [31:0] salt;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;
        int unsigned mb, n, room, total, beat_idx, r_left, ar_wait;
        int          last_hs_cyc;
        bit          exp_err, done_seen, rv_hold, in_data, aborted;

        ma = a & ~32'd7;
        mb = len >> 3;
        total = mb;
        while (mb > 0) begin
            room = (4096 - (ma % 4096)) / 8;
            n = mb;
            if (n > 16) n = 16;
            if (n > room) n = room;
            qa.push_back(ma);
            ql.push_back(n);
            ma = ma + n * 8;
            mb = mb - n;
        end
        exp_err = (resp_bad >= 1 && resp_bad <= total) || (rlast_bad >= 1 && rlast_bad <= total);
        salt = $urandom;
        beat_idx = 0; r_left = 0; ar_wait = 0; last_hs_cyc = -1;
        done_seen = 0; rv_hold = 0; aborted = 0;
        cap_addr = '0; cap_len = '0;

        @(negedge clk);
        run = 1'b1; start_addr = a; byte_length = 20'(len);
        @(negedge clk);
        run = 1'b0; start_addr = $urandom; byte_length = 20'($urandom);
        #1;
        check_eq("busy_start", busy, 1);
        check_eq("err_clear", err, 0);
        check_eq("done_start", done, 0);
        check_eq("arsize", m_axi_arsize, 3);
        check_eq("arburst", m_axi_arburst, 1);
        check_eq("arprot_lock", {m_axi_arprot, m_axi_arlock}, 0);

        for (int cyc = 0; cyc < 4000 && !done_seen && !aborted; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                #1;
            end
            if (done) begin
                done_seen = 1;
                m_axi_rvalid = 1'b0;
                check_eq("done_lat", 64'(cyc - last_hs_cyc), 2);
                check_eq("done_busy", busy, 0);
                check_eq("err_final", err, exp_err);
            end else begin
                check_eq("busy_hold", busy, 1);
                // Run during a busy transfer must be ignored
                run = (cyc == 1 && total > 0);
                if (m_axi_arvalid) begin
                    check_eq("ar_overlap", r_left, 0);
                    if (ar_wait == 0) begin
                        if (qa.size() == 0) begin
                            check_eq("ar_unexpected", m_axi_arvalid, 0);
                        end else begin
                            check_eq("ar_addr", m_axi_araddr, qa[0]);
                            check_eq("ar_len", m_axi_arlen, ql[0] - 1);
                        end
                        cap_addr = m_axi_araddr;
                        cap_len  = m_axi_arlen;
                    end else begin
                        check_eq("ar_stable_addr", m_axi_araddr, cap_addr);
                        check_eq("ar_stable_len", m_axi_arlen, cap_len);
                    end
                    m_axi_arready = (ar_wait >= ar_dly);
                end else begin
                    m_axi_arready = 1'($urandom_range(0, 1));
                end
                if (r_left > 0) begin
                    if (!rv_hold) begin
                        m_axi_rvalid = ($urandom_range(1, 100) <= rv_pct);
                        m_axi_rdata  = {salt, 32'(beat_idx + 1)};
                        m_axi_rresp  = (beat_idx + 1 == resp_bad) ? 2'd2 : 2'd0;
                        m_axi_rlast  = (r_left == 1);
                        if (beat_idx + 1 == rlast_bad) m_axi_rlast = ~m_axi_rlast;
                    end
                    rv_hold = m_axi_rvalid;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'd0;
                end
                m_axis_tready = ($urandom_range(1, 100) <= tr_pct);
                #1;
                in_data = (r_left > 0);
                check_eq("rready", m_axi_rready, in_data && m_axis_tready);
                check_eq("tvalid", m_axis_tvalid, in_data && m_axi_rvalid);
                if (m_axi_rvalid && m_axi_rready) begin
                    beat_idx++;
                    check_eq("tdata", m_axis_tdata, {salt, 32'(beat_idx)});
                    check_eq("tlast", m_axis_tlast, beat_idx == total);
                    r_left--;
                    rv_hold = 0;
                    last_hs_cyc = cyc;
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    if (ql.size() > 0) begin
                        r_left = ql[0];
                        void'(qa.pop_front());
                        void'(ql.pop_front());
                    end
                    ar_wait = 0;
                end else if (m_axi_arvalid) begin
                    ar_wait++;
                end
                if (abort_at != 0 && beat_idx == abort_at && r_left > 0) begin
                    #1;
                    rst = 1'b1;
                    #1;
                    check_idle_outputs("reset_mid");
                    aborted = 1;
                    m_axi_rvalid = 1'b0;
                    m_axis_tready = 1'b0;
                    run = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
        end
        run = 1'b0;
        if (!aborted) begin
            if (!done_seen) check_eq("done_timeout", done_seen, 1);
            check_eq("beats", beat_idx, total);
            check_eq("bursts_left", qa.size(), 0);
            @(negedge clk);
            #1;
            check_eq("done_pulse", done, 0);
            check_eq("err_hold", err, exp_err);
        end
    endtask

    initial begin
        int unsigned len, tot, rb, lb;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        run = 1'b0;
        start_addr = '0;
        byte_length = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'd0;
        m_axis_tready = 1'b0;
        #3;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_xfer(32'h0000_1000, 64, 100, 100, 0, 0, 0, 0);
        do_xfer(32'h0000_0000, 1000, 100, 100, 0, 0, 0, 0);
        do_xfer(32'h0000_0FE0, 128, 100, 100, 0, 0, 0, 0);
        do_xfer(32'h0000_2000, 5, 100, 100, 0, 0, 0, 0);
        do_xfer(32'h0000_3000, 256, 50, 100, 5, 0, 0, 0);
        do_xfer(32'h0000_1000, 64, 100, 100, 0, 3, 6, 0);
        do_xfer(32'h0000_1000, 64, 70, 70, 1, 0, 0, 0);
        do_xfer(32'h0000_1000, 64, 100, 100, 0, 0, 8, 0);
        do_xfer(32'hFFFF_FFC0, 256, 80, 80, 2, 0, 0, 0);
        do_xfer(32'h0000_5000, 256, 80, 80, 1, 0, 0, 10);
        do_xfer(32'h0000_6008, 200, 90, 90, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            len = $urandom_range(0, 1500);
            tot = len >> 3;
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot + 1) : 0;
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot + 1) : 0;
            do_xfer($urandom, len, $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(0, 3), rb, lb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
